// File: rtl/pipe_pkg.sv
// Shared pipeline encodings for the hazard sequencer.
// Also holds the NOP word and MemCtrl field layout used by the datapath.
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    FLUSH   = 2'd1,
    MEMWAIT = 2'd2
  } ctrl_state_e;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  localparam int MEMCTRL_READ_BIT = 1;

  localparam int FCNT_W = 2;

  typedef struct packed {
    logic pcWrite;
    logic pcRedirect;
    logic ifidWrite;
    logic ifidFlush;
    logic idexWrite;
    logic idexBubble;
    logic exmemWrite;
  } hz_ctrl_t;

  function automatic hz_ctrl_t hz_idle();
    hz_ctrl_t c;
    c            = '0;
    c.pcWrite    = 1'b1;
    c.ifidWrite  = 1'b1;
    c.idexWrite  = 1'b1;
    c.exmemWrite = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/hazard_compare.sv
// Load-use detector: ID/EX load writing a register IF/ID reads.
// Pure combinational so a forwarding unit can reuse it.
module hazard_compare
  import pipe_pkg::*;
(
  input  logic [4:0] i_rs1,
  input  logic [4:0] i_rs2,
  input  logic       i_useRs1,
  input  logic       i_useRs2,
  input  logic [4:0] i_rd,
  input  logic       i_memRead,
  output logic       o_loadUse
);

  logic w_hit1;
  logic w_hit2;

  assign w_hit1 = i_useRs1 & (i_rd == i_rs1);
  assign w_hit2 = i_useRs2 & (i_rd == i_rs2);

  // x0 is hardwired zero, never a real dependency
  assign o_loadUse = i_memRead & (|i_rd) & (w_hit1 | w_hit2);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32 pipeline.
// Define HAZARD_PERF_CNT_EN to add saturating performance counters.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] ifidRs1,
  input  logic [4:0] ifidRs2,
  input  logic       ifidUseRs1,
  input  logic       ifidUseRs2,
  input  logic [4:0] idexRd,
  input  logic       idexMemRead,
  input  logic       exBranchTaken,
  input  logic       memBusy,
  output logic       pcWrite,
  output logic       pcRedirect,
  output logic       ifidWrite,
  output logic       ifidFlush,
  output logic       idexWrite,
  output logic       idexBubble,
  output logic       exmemWrite,
  output logic [1:0] ctrlState
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stallCycles,
  output logic [CNT_W-1:0] flushCycles,
  output logic [CNT_W-1:0] memWaitCycles
`endif
);

  localparam int FC = (FLUSH_CYCLES < 1) ? 1 :
                      (FLUSH_CYCLES > 3) ? 3 : FLUSH_CYCLES;
  localparam logic [FCNT_W-1:0] FLUSH_RELOAD = FCNT_W'(FC - 1);

  ctrl_state_e       r_state;
  ctrl_state_e       w_nState;
  logic [FCNT_W-1:0] r_flushCnt;
  logic [FCNT_W-1:0] w_nFlushCnt;
  logic              r_pend;
  logic              w_nPend;

  logic     w_loadUse;
  logic     w_freeze;
  logic     w_redir;
  logic     w_hold;
  logic     w_bubble;
  hz_ctrl_t w_ctl;

  hazard_compare u_cmp (
    .i_rs1     (ifidRs1),
    .i_rs2     (ifidRs2),
    .i_useRs1  (ifidUseRs1),
    .i_useRs2  (ifidUseRs2),
    .i_rd      (idexRd),
    .i_memRead (idexMemRead),
    .o_loadUse (w_loadUse)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= RUN;
      r_flushCnt <= '0;
      r_pend     <= 1'b0;
    end else begin
      r_state    <= w_nState;
      r_flushCnt <= w_nFlushCnt;
      r_pend     <= w_nPend;
    end
  end

  // One action per cycle: freeze > redirect > flush hold > bubble
  always_comb begin
    w_freeze = 1'b0;
    w_redir  = 1'b0;
    w_hold   = 1'b0;
    w_bubble = 1'b0;
    if (!rst) begin
      if (memBusy) begin
        w_freeze = 1'b1;
      end else if (exBranchTaken |
                   ((r_state == MEMWAIT) & r_pend)) begin
        w_redir = 1'b1;
      end else if (r_state == FLUSH) begin
        w_hold = 1'b1;
      end else if (w_loadUse) begin
        w_bubble = 1'b1;
      end
    end
  end

  always_comb begin
    w_nState    = RUN;
    w_nFlushCnt = '0;
    w_nPend     = 1'b0;
    if (w_freeze) begin
      w_nState = MEMWAIT;
      w_nPend  = r_pend | exBranchTaken;
    end else if (w_redir) begin
      w_nFlushCnt = FLUSH_RELOAD;
      w_nState    = (FC > 1) ? FLUSH : RUN;
    end else if (w_hold) begin
      w_nFlushCnt = r_flushCnt - 1'b1;
      w_nState    = (r_flushCnt > 1) ? FLUSH : RUN;
    end
  end

  always_comb begin
    w_ctl = hz_idle();
    if (w_freeze) begin
      w_ctl.pcWrite    = 1'b0;
      w_ctl.ifidWrite  = 1'b0;
      w_ctl.idexWrite  = 1'b0;
      w_ctl.exmemWrite = 1'b0;
    end
    if (w_bubble) begin
      w_ctl.pcWrite    = 1'b0;
      w_ctl.ifidWrite  = 1'b0;
      w_ctl.idexBubble = 1'b1;
    end
    if (w_redir) begin
      w_ctl.pcRedirect = 1'b1;
      w_ctl.ifidFlush  = 1'b1;
      w_ctl.idexBubble = 1'b1;
    end
    if (w_hold) begin
      w_ctl.ifidFlush = 1'b1;
    end
  end

  assign pcWrite    = w_ctl.pcWrite;
  assign pcRedirect = w_ctl.pcRedirect;
  assign ifidWrite  = w_ctl.ifidWrite;
  assign ifidFlush  = w_ctl.ifidFlush;
  assign idexWrite  = w_ctl.idexWrite;
  assign idexBubble = w_ctl.idexBubble;
  assign exmemWrite = w_ctl.exmemWrite;
  assign ctrlState  = r_state;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall;
  logic [CNT_W-1:0] r_flush;
  logic [CNT_W-1:0] r_mwait;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall <= '0;
      r_flush <= '0;
      r_mwait <= '0;
    end else begin
      if (w_bubble && (r_stall != '1)) begin
        r_stall <= r_stall + 1'b1;
      end
      if (w_ctl.ifidFlush && (r_flush != '1)) begin
        r_flush <= r_flush + 1'b1;
      end
      if ((r_state == MEMWAIT) && (r_mwait != '1)) begin
        r_mwait <= r_mwait + 1'b1;
      end
    end
  end

  assign stallCycles   = r_stall;
  assign flushCycles   = r_flush;
  assign memWaitCycles = r_mwait;
`else
  if (CNT_W < 1) begin : g_cnt_w_invalid
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed cases then random traffic,
// all cycles compared against a rule-level model.
module tb_pipe_hazard_ctrl;

  localparam int FC = 2;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] ifidRs1, ifidRs2, idexRd;
  logic       ifidUseRs1, ifidUseRs2;
  logic       idexMemRead, exBranchTaken, memBusy;
  logic       pcWrite, pcRedirect, ifidWrite, ifidFlush;
  logic       idexWrite, idexBubble, exmemWrite;
  logic [1:0] ctrlState;
`ifdef HAZARD_PERF_CNT_EN
  logic [CW-1:0] stallCycles, flushCycles, memWaitCycles;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .clk           (clk),
    .rst           (rst),
    .ifidRs1       (ifidRs1),
    .ifidRs2       (ifidRs2),
    .ifidUseRs1    (ifidUseRs1),
    .ifidUseRs2    (ifidUseRs2),
    .idexRd        (idexRd),
    .idexMemRead   (idexMemRead),
    .exBranchTaken (exBranchTaken),
    .memBusy       (memBusy),
    .pcWrite       (pcWrite),
    .pcRedirect    (pcRedirect),
    .ifidWrite     (ifidWrite),
    .ifidFlush     (ifidFlush),
    .idexWrite     (idexWrite),
    .idexBubble    (idexBubble),
    .exmemWrite    (exmemWrite),
    .ctrlState     (ctrlState)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stallCycles   (stallCycles),
    .flushCycles   (flushCycles),
    .memWaitCycles (memWaitCycles)
`endif
  );

  function automatic logic [8:0] outs();
    return {pcWrite, pcRedirect, ifidWrite, ifidFlush,
            idexWrite, idexBubble, exmemWrite, ctrlState};
  endfunction

  // Model: waiting flag, pending redirect, remaining flush cycles
  bit mWait = 0;
  bit mPend = 0;
  int mLeft = 0;
  int mStall = 0, mFlush = 0, mMwait = 0;

  always @(negedge clk) begin
    automatic bit lu;
    automatic bit pw = 1, pr = 0, iw = 1, fl = 0;
    automatic bit xw = 1, xb = 0, mw = 1;
    automatic bit bub = 0;
    automatic int st;
    automatic bit nWait = 0, nPend = 0;
    automatic int nLeft = 0;
    automatic logic [8:0] exp;
    lu = idexMemRead && (idexRd != 0) &&
         ((ifidUseRs1 && idexRd == ifidRs1) ||
          (ifidUseRs2 && idexRd == ifidRs2));
    st = mWait ? 2 : ((mLeft > 0) ? 1 : 0);
    if (rst) begin
    end else if (memBusy) begin
      pw = 0; iw = 0; xw = 0; mw = 0;
      nWait = 1;
      nPend = mPend | exBranchTaken;
    end else if (exBranchTaken || mPend) begin
      pr = 1; fl = 1; xb = 1;
      nLeft = FC - 1;
    end else if (mLeft > 0) begin
      fl = 1;
      nLeft = mLeft - 1;
    end else if (lu) begin
      pw = 0; iw = 0; xb = 1; bub = 1;
    end
    exp = {pw, pr, iw, fl, xw, xb, mw, 2'(st)};
    checks++;
    if (outs() !== exp) begin
      errors++;
      $display("FAIL model_outs t=%0t got %b want %b", $time, outs(), exp);
    end
`ifdef HAZARD_PERF_CNT_EN
    checks++;
    if ({stallCycles, flushCycles, memWaitCycles} !==
        {CW'(mStall), CW'(mFlush), CW'(mMwait)}) begin
      errors++;
      $display("FAIL model_cnt t=%0t got %0d/%0d/%0d want %0d/%0d/%0d",
               $time, stallCycles, flushCycles, memWaitCycles,
               mStall, mFlush, mMwait);
    end
    if (rst) begin
      mStall = 0; mFlush = 0; mMwait = 0;
    end else begin
      if (bub) mStall = (mStall < CMAX) ? mStall + 1 : CMAX;
      if (fl) mFlush = (mFlush < CMAX) ? mFlush + 1 : CMAX;
      if (st == 2) mMwait = (mMwait < CMAX) ? mMwait + 1 : CMAX;
    end
`endif
    mWait = nWait;
    mPend = nPend;
    mLeft = nLeft;
  end

  task automatic drive(input bit r, input bit b, input bit m,
                       input bit mr, input logic [4:0] rd,
                       input logic [4:0] rs1, input bit u1,
                       input logic [4:0] rs2, input bit u2);
    @(posedge clk);
    #1;
    rst = r; exBranchTaken = b; memBusy = m;
    idexMemRead = mr; idexRd = rd;
    ifidRs1 = rs1; ifidUseRs1 = u1;
    ifidRs2 = rs2; ifidUseRs2 = u2;
    @(negedge clk);
    #1;
  endtask

  task automatic pin(input string nm, input logic [8:0] exp);
    checks++;
    if (outs() !== exp) begin
      errors++;
      $display("FAIL %s got %b want %b", nm, outs(), exp);
    end
  endtask

  // Order: pcWrite pcRedirect ifidWrite ifidFlush idexWrite
  //        idexBubble exmemWrite ctrlState[1:0]
  localparam logic [8:0] IDLE = 9'b1010101_00;
  localparam logic [8:0] BUB  = 9'b0000111_00;
  localparam logic [8:0] RDR0 = 9'b1111111_00;
  localparam logic [8:0] RDR2 = 9'b1111111_10;
  localparam logic [8:0] FLS  = 9'b1011101_01;
  localparam logic [8:0] FRZ0 = 9'b0000000_00;
  localparam logic [8:0] FRZ2 = 9'b0000000_10;

  initial begin
    rst = 1; exBranchTaken = 0; memBusy = 0;
    idexMemRead = 0; idexRd = 0;
    ifidRs1 = 0; ifidRs2 = 0; ifidUseRs1 = 0; ifidUseRs2 = 0;

    drive(1, 0, 0, 0, 0, 0, 0, 0, 0); pin("reset0", IDLE);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0); pin("reset1", IDLE);

    drive(0, 0, 0, 1, 5, 5, 1, 1, 1); pin("loaduse", BUB);
    drive(0, 0, 0, 0, 5, 5, 1, 1, 1); pin("lu_after", IDLE);
    drive(0, 0, 0, 1, 0, 0, 1, 0, 1); pin("rd_zero", IDLE);
    drive(0, 0, 0, 1, 5, 5, 0, 5, 0); pin("no_use", IDLE);
    drive(0, 0, 0, 1, 7, 1, 1, 7, 1); pin("lu_rs2", BUB);
    drive(0, 0, 0, 0, 7, 1, 1, 7, 1); pin("lu2_after", IDLE);

    drive(0, 1, 0, 0, 0, 0, 0, 0, 0); pin("br_c0", RDR0);
    drive(0, 0, 0, 1, 5, 5, 1, 0, 0); pin("br_c1", FLS);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); pin("br_c2", IDLE);

    drive(0, 0, 1, 0, 0, 0, 0, 0, 0); pin("mw_c0", FRZ0);
    drive(0, 1, 1, 0, 0, 0, 0, 0, 0); pin("mw_c1", FRZ2);
    drive(0, 0, 1, 0, 0, 0, 0, 0, 0); pin("mw_c2", FRZ2);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); pin("mw_rel", RDR2);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); pin("mw_fl", FLS);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); pin("mw_done", IDLE);

    drive(0, 1, 1, 1, 5, 5, 1, 0, 0); pin("all3", FRZ0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); pin("all3_rel", RDR2);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); pin("all3_fl", FLS);

    drive(0, 1, 1, 0, 0, 0, 0, 0, 0); pin("rst_pre0", FRZ0);
    drive(0, 0, 1, 0, 0, 0, 0, 0, 0); pin("rst_pre1", FRZ2);
    drive(1, 0, 1, 0, 0, 0, 0, 0, 0); pin("rst_mw", 9'b1010101_10);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); pin("rst_after", IDLE);
`ifdef HAZARD_PERF_CNT_EN
    checks++;
    if ({stallCycles, flushCycles, memWaitCycles} !== '0) begin
      errors++;
      $display("FAIL rst_cnt got %0d/%0d/%0d want 0/0/0",
               stallCycles, flushCycles, memWaitCycles);
    end
`endif
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); pin("rst_after1", IDLE);

    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 99) < 1,
            $urandom_range(0, 99) < 15,
            $urandom_range(0, 99) < 20,
            $urandom_range(0, 1) == 1,
            5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
            5'($urandom_range(0, 3)), $urandom_range(0, 1) == 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
